// File: rtl/harm_sched_25b.sv
// Round-robin scheduler that shares one hrm_25b rotator between N_CH sin/cos oscillators.
// Each channel holds its state, its step and a period counter; one channel is rotated per cycle.

// hrm_25b: {sin,cos} pairs of signed Q2.23 values (1.0 = 25'h0800000).
// A step is a complex multiply; products are truncated by an arithmetic shift and wrap to 25 bits.
module hrm_25b (
  input  logic [49:0] i_alpha,
  input  logic [49:0] i_delta,
  output logic [49:0] o_alpha
);
  logic signed [24:0] a_s, a_c, d_s, d_c;

  assign a_s = i_alpha[49:25];
  assign a_c = i_alpha[24:0];
  assign d_s = i_delta[49:25];
  assign d_c = i_delta[24:0];

  assign o_alpha[49:25] = 25'((51'(a_s) * 51'(d_c) + 51'(a_c) * 51'(d_s)) >>> 23);
  assign o_alpha[24:0]  = 25'((51'(a_c) * 51'(d_c) - 51'(a_s) * 51'(d_s)) >>> 23);
endmodule

// Config handshake: a write is taken at any rising edge with i_cfg_valid && o_cfg_ready.
// o_cfg_ready is low through reset and for the first edge after release, high otherwise.
module harm_sched_25b #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int DIV_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cfg_valid,
  input  logic [CH_W-1:0]        i_cfg_ch,
  input  logic [49:0]            i_cfg_alpha,
  input  logic [49:0]            i_cfg_delta,
  input  logic [DIV_W-1:0]       i_cfg_period,
  output logic                   o_cfg_ready,
  input  logic [N_CH-1:0]        i_ch_en,
  input  logic                   i_ovr_clr,
  output logic [50*N_CH-1:0]     o_theta,
  output logic                   o_upd_valid,
  output logic [CH_W-1:0]        o_upd_ch,
  output logic [N_CH-1:0]        o_overrun
);
  localparam logic [CH_W:0]   NCH_EXT = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  logic [49:0]      alpha_q  [N_CH];
  logic [49:0]      delta_q  [N_CH];
  logic [DIV_W-1:0] period_q [N_CH];
  logic [DIV_W-1:0] cnt_q    [N_CH];
  logic [N_CH-1:0]  pending_q, overrun_q;
  logic [CH_W-1:0]  ptr_q;
  logic             ready_q;
  logic             upd_valid_q;
  logic [CH_W-1:0]  upd_ch_q;

  logic             cfg_fire;
  logic [N_CH-1:0]  cfg_hit;
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  eligible;
  logic             grant_vld;
  logic [CH_W-1:0]  grant_idx;
  logic [CH_W-1:0]  ptr_nxt;
  logic [N_CH-1:0]  pending_nxt, overrun_nxt;
  logic [49:0]      rot_alpha;

  assign cfg_fire = i_cfg_valid & ready_q;

  always_comb begin
    cfg_hit = '0;
    req     = '0;
    for (int k = 0; k < N_CH; k++) begin
      cfg_hit[k] = cfg_fire && (i_cfg_ch == CH_W'(k));
      req[k]     = ready_q && i_ch_en[k] && (cnt_q[k] == '0) && !cfg_hit[k];
    end
  end

  // Search starts at the pointer and wraps; a config write suppresses the grant entirely.
  always_comb begin : arb
    logic [CH_W:0] idx;
    eligible  = pending_q & i_ch_en;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = {1'b0, ptr_q} + (CH_W+1)'(i);
      if (idx >= NCH_EXT) idx = idx - NCH_EXT;
      if (!grant_vld && eligible[idx[CH_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = idx[CH_W-1:0];
      end
    end
    if (cfg_fire || !ready_q) grant_vld = 1'b0;
    ptr_nxt = (grant_idx == LAST_CH) ? '0 : grant_idx + CH_W'(1);
  end

  // A new request on the granted channel keeps it pending without flagging an overrun.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      pending_nxt[k] = pending_q[k];
      overrun_nxt[k] = overrun_q[k] & ~i_ovr_clr;
      if (cfg_hit[k]) begin
        pending_nxt[k] = 1'b0;
        overrun_nxt[k] = 1'b0;
      end else begin
        if (grant_vld && (grant_idx == CH_W'(k))) pending_nxt[k] = 1'b0;
        if (req[k]) begin
          pending_nxt[k] = 1'b1;
          if (pending_q[k] && !(grant_vld && (grant_idx == CH_W'(k)))) overrun_nxt[k] = 1'b1;
        end
      end
    end
  end

  hrm_25b u_rot (
    .i_alpha (alpha_q[grant_idx]),
    .i_delta (delta_q[grant_idx]),
    .o_alpha (rot_alpha)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      ready_q     <= 1'b0;
      ptr_q       <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
      upd_valid_q <= 1'b0;
      upd_ch_q    <= '0;
      for (int k = 0; k < N_CH; k++) begin
        alpha_q[k]  <= '0;
        delta_q[k]  <= '0;
        period_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
    end else begin
      ready_q     <= 1'b1;
      pending_q   <= pending_nxt;
      overrun_q   <= overrun_nxt;
      upd_valid_q <= grant_vld;
      if (grant_vld) begin
        upd_ch_q           <= grant_idx;
        ptr_q              <= ptr_nxt;
        alpha_q[grant_idx] <= rot_alpha;
      end
      for (int k = 0; k < N_CH; k++) begin
        if (cfg_hit[k]) begin
          alpha_q[k]  <= i_cfg_alpha;
          delta_q[k]  <= i_cfg_delta;
          period_q[k] <= i_cfg_period;
          cnt_q[k]    <= i_cfg_period;
        end else if (ready_q && i_ch_en[k]) begin
          cnt_q[k] <= (cnt_q[k] == '0) ? period_q[k] : cnt_q[k] - DIV_W'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_theta
    assign o_theta[k*50 +: 50] = alpha_q[k];
  end

  assign o_cfg_ready = ready_q;
  assign o_upd_valid = upd_valid_q;
  assign o_upd_ch    = upd_ch_q;
  assign o_overrun   = overrun_q;
endmodule

// File: doc/harm_sched_25b.md
Name: harm_sched_25b

Overview:
- Time-multiplexes one hrm_25b rotation unit across N_CH independent sin/cos oscillator channels.
- Each channel holds its own state vector (alpha) and rotation step (delta) in local registers, plus a programmable step period.
- A per-channel period counter raises step requests. A round-robin arbiter grants at most one channel per cycle; the granted channel's state is rotated and written back.
- Sits between the configuration bus and the waveform consumers; replaces one harm_gen_25b instance per tone.

Parameters:
N_CH, 4, number of oscillator channels (2..16)
CH_W, 2, channel index width, equal to clog2(N_CH)
DIV_W, 16, period counter width

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-low reset; 0 = reset
i_cfg_valid  in  1  configuration write strobe
i_cfg_ch  in  CH_W  channel being configured
i_cfg_alpha  in  25x2  initial state {sin,cos}, hrm_25b format
i_cfg_delta  in  25x2  rotation step, hrm_25b format
i_cfg_period  in  DIV_W  step period P; one step every P+1 enabled cycles
o_cfg_ready  out  1  configuration accept (always 1 outside reset)
i_ch_en  in  N_CH  per-channel run enable
i_ovr_clr  in  1  clears all overrun flags
o_theta  out  25x2xN_CH  current state of each channel (registered alpha)
o_upd_valid  out  1  one-cycle pulse: a channel state was updated at this edge
o_upd_ch  out  CH_W  channel updated; valid with o_upd_valid
o_overrun  out  N_CH  sticky: a step request was lost on that channel

Behaviour:
- Reset (i_rst==0 at a rising edge):
  - All alpha, delta, period and counter registers clear to 0.
  - pending, overrun, RR pointer, o_upd_valid and o_upd_ch clear to 0.
  - o_cfg_ready is 0 during reset and 1 otherwise.
  - Reset mid-operation discards all pending steps. The first possible update is 2 cycles after the release edge.
- Counter (per channel k, only while i_ch_en[k]):
  - If cnt==0: cnt <= period and a request fires.
  - Otherwise cnt decrements.
  - When disabled, cnt holds and no requests fire.
- Request:
  - A request sets pending[k].
  - If pending[k] is already 1 and is not being granted this cycle, also set overrun[k]. Requests merge; they never queue.
- Arbitration, each cycle:
  - Eligible channels are those with pending[k] & i_ch_en[k].
  - Search begins at the RR pointer and wraps modulo N_CH. The first eligible channel g is granted.
  - On grant: alpha[g] <= hrm_25b(alpha[g], delta[g]), pending[g] <= 0, pointer <= (g+1) mod N_CH.
  - o_upd_valid <= 1 and o_upd_ch <= g at the same edge.
  - A disabled channel's pending bit is retained and is served after re-enable.
- Same-cycle grant and new request on channel g: pending[g] stays 1; no overrun.
- Configuration (i_cfg_valid & o_cfg_ready) has priority:
  - No grant is issued that cycle; the RR pointer is unchanged and o_upd_valid is 0 next cycle.
  - Channel c=i_cfg_ch loads alpha, delta and period, sets cnt <= period, and clears pending[c] and overrun[c].
  - Counters on other channels keep running; their requests still set pending and overrun.
  - i_cfg_ch >= N_CH is ignored, but the stall cycle still applies.
- Single hrm_25b instance, combinational. Operand mux uses the grant index; write-back is a registered 25-bit pass-through with no width growth. Latency: request edge -> pending -> grant edge updates o_theta, minimum 1 cycle after pending sets.
- o_theta[k] always reflects the stored alpha[k].
- i_ovr_clr clears all overrun bits. A new overrun in the same cycle wins (set has priority).
- Throughput: 1 step per cycle aggregate. Sum over channels of 1/(P_k+1) > 1 produces overruns.

Test Plan:
- Reset: hold i_rst=0 for 3 cycles with cfg/enable activity -> all o_theta=0, o_upd_valid=0, o_overrun=0, o_cfg_ready=0; it rises to 1 on the first cycle after release.
- Single channel: cfg ch0 with period=3, delta=identity rotation, alpha=A, then en=0001 -> o_upd_valid with o_upd_ch=0 every 4 cycles; o_theta[0] stays A. With delta=D, successive o_theta[0] values match the golden hrm_25b model iterated 10 times.
- Round-robin: 4 channels, period=0, all enabled -> updates on channels 0,1,2,3,0,1,… one per cycle; o_overrun becomes 4'b1111 within 2 cycles; i_ovr_clr pulse clears, and the flags re-set the next cycle.
- Overrun boundary: ch0 period=1 and ch1 period=1, both enabled -> alternating grants with no overrun. Change ch0 to period=0 -> ch0 and ch1 overrun bits set.
- Config priority: a cfg write on the cycle ch2 would be granted -> no o_upd_valid next cycle; ch2 is served on the following eligible cycle; a cfg write to ch2 while it is pending clears pending and overrun.
- Enable gating: drop i_ch_en[1] while pending[1]=1 -> no update for ch1 and its cnt frozen for 20 cycles; re-enable -> ch1 updates within N_CH cycles.
